// File: rtl/sm_stack_ctrl.sv
// sm_stack_ctrl: stack-pointer sequencer driving a 1-cycle-latency sync stack RAM
module sm_stack_ctrl #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] sp,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);
  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  state_t state, state_n;
  logic acc, rd_go;
  assign cmd_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign acc        = cmd_valid & cmd_ready & ~rst;
  assign full       = count == DEPTH;
  assign empty      = count == '0;
  // op 01 (POP) and 10 (PEEK) are the only ops with odd parity: both need a RAM read
  assign rd_go      = acc & ^cmd_op & ~empty;
  assign mem_we     = acc & (cmd_op == 2'b00) & ~full;
  assign mem_addr   = (cmd_op == 2'b00) ? sp : sp + AW'(1);
  assign mem_wdata  = cmd_wdata;
  // next state: reads detour through RD to catch RAM data, everything else answers next cycle
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (acc ? (rd_go ? RD : RESP) : IDLE) :
              (state == RD)   ? RESP :
              (resp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // committed stack state and response registers; POP moves sp at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '1;
      count     <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (acc) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
      if (cmd_op == 2'b11) begin
        sp    <= '1;
        count <= '0;
        ovf   <= 1'b0;
        unf   <= 1'b0;
      end else if (cmd_op == 2'b00) begin
        if (full) begin
          ovf      <= 1'b1;
          resp_err <= 1'b1;
        end else begin
          sp    <= sp - AW'(1);
          count <= count + (AW+1)'(1);
        end
      end else if (empty) begin
        unf      <= 1'b1;
        resp_err <= 1'b1;
      end else if (cmd_op == 2'b01) begin
        sp    <= sp + AW'(1);
        count <= count - (AW+1)'(1);
      end
    end else if (state == RD) begin
      resp_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_sm_stack_ctrl.sv
// tb_sm_stack_ctrl: directed vector table plus hand sequences for sm_stack_ctrl
module tb_sm_stack_ctrl;
  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, PEEK = 2'b10, CLR = 2'b11;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, resp_valid, resp_ready = 1, resp_err, mem_we;
  logic [1:0] cmd_op = 0;
  logic [31:0] cmd_wdata = 0, resp_data, mem_wdata, mem_rdata;
  logic [4:0] mem_addr, sp;
  logic [5:0] count;
  logic full, empty, ovf, unf;
  logic [31:0] ram [32];
  int total = 0, bad = 0;

  sm_stack_ctrl #(.AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .sp(sp), .count(count), .full(full),
    .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [1:0] op; logic [31:0] wd; bit we; bit err; logic [31:0] data;
    int lat; logic [4:0] sp; logic [5:0] cnt; bit ovf; bit unf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    cmd_valid = 1; cmd_op = v.op; cmd_wdata = v.wd;
    #1;
    chk({nm, ".we"}, 64'(mem_we), 64'(v.we));
    if (v.we) begin
      chk({nm, ".addr"}, 64'(mem_addr), 64'(5'(v.sp + 5'd1)));
      chk({nm, ".wdata"}, 64'(mem_wdata), 64'(v.wd));
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, ".lat"}, 64'(lat), 64'(v.lat));
    chk({nm, ".err"}, 64'(resp_err), 64'(v.err));
    chk({nm, ".data"}, 64'(resp_data), 64'(v.data));
    @(posedge clk); #1;
    chk({nm, ".idle"}, 64'(cmd_ready), 64'd1);
    chk({nm, ".sp"}, 64'(sp), 64'(v.sp));
    chk({nm, ".cnt"}, 64'(count), 64'(v.cnt));
    chk({nm, ".ovf"}, 64'(ovf), 64'(v.ovf));
    chk({nm, ".unf"}, 64'(unf), 64'(v.unf));
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    tbl[0]  = '{PUSH, 32'hA5A5A5A5, 1, 0, 0,     1, 30, 1, 0, 0};
    tbl[1]  = '{CLR,  0,            0, 0, 0,     1, 31, 0, 0, 0};
    tbl[2]  = '{PUSH, 32'h11,       1, 0, 0,     1, 30, 1, 0, 0};
    tbl[3]  = '{PUSH, 32'h22,       1, 0, 0,     1, 29, 2, 0, 0};
    tbl[4]  = '{POP,  0,            0, 0, 32'h22, 2, 30, 1, 0, 0};
    tbl[5]  = '{POP,  0,            0, 0, 32'h11, 2, 31, 0, 0, 0};
    tbl[6]  = '{POP,  0,            0, 1, 0,     1, 31, 0, 0, 1};
    tbl[7]  = '{CLR,  0,            0, 0, 0,     1, 31, 0, 0, 0};
    tbl[8]  = '{PUSH, 32'h77,       1, 0, 0,     1, 30, 1, 0, 0};
    tbl[9]  = '{PEEK, 0,            0, 0, 32'h77, 2, 30, 1, 0, 0};
    tbl[10] = '{PEEK, 0,            0, 0, 32'h77, 2, 30, 1, 0, 0};
    tbl[11] = '{CLR,  0,            0, 0, 0,     1, 31, 0, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst.sp", 64'(sp), 64'd31);
    chk("rst.cnt", 64'(count), 64'd0);
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.rvalid", 64'(resp_valid), 64'd0);
    chk("rst.rdata", 64'(resp_data), 64'd0);
    chk("rst.flags", 64'({ovf, unf, resp_err}), 64'd0);

    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("v%0d", i));

    for (int i = 0; i < 32; i++) begin
      v = '{PUSH, 32'(i + 100), 1, 0, 0, 1, 5'(30 - i), 6'(i + 1), 0, 0};
      run(v, $sformatf("fill%0d", i));
    end
    chk("fill.full", 64'(full), 64'd1);
    run('{PUSH, 32'hDEAD, 0, 1, 0, 1, 31, 32, 1, 0}, "ovf");
    chk("ovf.full", 64'(full), 64'd1);
    run('{POP, 0, 0, 0, 32'd131, 2, 0, 31, 1, 0}, "popwrap");
    run('{CLR, 0, 0, 0, 0, 1, 31, 0, 0, 0}, "clr2");

    run('{PUSH, 32'h99, 1, 0, 0, 1, 30, 1, 0, 0}, "prerst");
    @(negedge clk);
    cmd_valid = 1; cmd_op = POP;
    @(negedge clk);
    cmd_valid = 0;
    chk("rst6.inrd", 64'(cmd_ready | resp_valid), 64'd0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst6.norsp%0d", i), 64'(resp_valid), 64'd0);
      @(negedge clk);
    end
    chk("rst6.sp", 64'(sp), 64'd31);
    chk("rst6.cnt", 64'(count), 64'd0);
    chk("rst6.idle", 64'(cmd_ready), 64'd1);

    run('{PUSH, 32'h5A, 1, 0, 0, 1, 30, 1, 0, 0}, "pre7");
    @(negedge clk);
    resp_ready = 0; cmd_valid = 1; cmd_op = PEEK;
    @(negedge clk);
    cmd_op = CLR;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d.rv", i), 64'(resp_valid), 64'd1);
      chk($sformatf("hold%0d.data", i), 64'(resp_data), 64'h5A);
      chk($sformatf("hold%0d.rdy", i), 64'(cmd_ready), 64'd0);
      chk($sformatf("hold%0d.cnt", i), 64'(count), 64'd1);
      @(negedge clk);
    end
    cmd_valid = 0; resp_ready = 1;
    @(negedge clk);
    chk("hold.idle", 64'(cmd_ready), 64'd1);
    chk("hold.cnt", 64'(count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
